// File: rtl/hdlc_pkg.sv
// Shared constants and types for the HDLC receive path.
//   FLAG_PATTERN  : window contents of an opening/closing flag (01111110)
//   ABORT_PATTERN : window contents of an abort (a 0 followed by seven 1s)
//   STUFF_ONES    : run of 1s after which the transmitter inserts a 0
//   rx_state_t    : frame state (IDLE, OPEN, DATA)
package hdlc_pkg;

   localparam logic [7:0] FLAG_PATTERN  = 8'h7E;
   localparam logic [7:0] ABORT_PATTERN = 8'h7F;
   localparam logic [2:0] STUFF_ONES    = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      DATA = 2'd2
   } rx_state_t;

endpackage

// File: rtl/hdlc_rx_destuff.sv
// Zero removal and LSB-first byte assembly on the delayed receive stream.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous reset, active-high
//   clear_i     : drops all partial state (held while no frame is open)
//   bit_i       : next bit of the delayed stream
//   bit_en_i    : bit_i is a data candidate this cycle
//   kept_o      : one-cycle strobe, a bit was kept (not a stuffed zero)
//   byte_done_o : one-cycle strobe, byte_o holds a completed byte
//   byte_o      : assembled byte, bit 0 = first kept bit
//   bit_cnt_o   : kept bits modulo 8 (0 means octet aligned)
module hdlc_rx_destuff
   import hdlc_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       bit_i,
   input  logic       bit_en_i,
   output logic       kept_o,
   output logic       byte_done_o,
   output logic [7:0] byte_o,
   output logic [2:0] bit_cnt_o
);

   logic [2:0] ones_q, ones_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       kept_q, kept_d;
   logic       done_q, done_d;

   always_comb begin
      ones_d    = ones_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      kept_d    = 1'b0;
      done_d    = 1'b0;
      if (clear_i) begin
         ones_d    = '0;
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (bit_en_i) begin
         if (!bit_i && (ones_q == STUFF_ONES)) begin
            // Stuffed zero: dropped, only the run of ones restarts.
            ones_d = '0;
         end else begin
            // Saturate so a long run of ones cannot wrap back to 5.
            ones_d    = bit_i ? ((ones_q == 3'd7) ? ones_q : ones_q + 3'd1) : 3'd0;
            shift_d   = {bit_i, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            kept_d    = 1'b1;
            done_d    = (bit_cnt_q == 3'd7);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ones_q    <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         kept_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         ones_q    <= ones_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         kept_q    <= kept_d;
         done_q    <= done_d;
      end
   end

   // The shift register holds the finished byte in the cycle the strobe is high.
   assign kept_o      = kept_q;
   assign byte_done_o = done_q;
   assign byte_o      = shift_q;
   assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: rtl/hdlc_rx_framer.sv
// HDLC receive front-end: flag/abort detection, frame tracking, byte output.
//   Clk, Rst        : clock and synchronous active-high reset
//   Rx, Rx_Enable   : serial line (one bit per clock) and receiver enable
//   Rx_FlagDetect   : pulse, flag seen on the line
//   Rx_AbortDetect  : pulse, abort seen on the line
//   Rx_AbortSignal  : pulse, abort terminated an open frame
//   Rx_ValidFrame   : high while a frame is open
//   Rx_Data/WrBuff  : assembled byte and its write strobe
//   Rx_EoF          : pulse, frame closed by a flag
//   Rx_FrameError   : with Rx_EoF, frame was empty or not octet aligned
//   Rx_Overflow     : sticky, frame carried more than MAX_BYTES bytes
module hdlc_rx_framer
   import hdlc_pkg::*;
#(
   parameter int MAX_BYTES = 128,
   parameter int CNT_W     = 8
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       Rx_Enable,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       Rx_AbortSignal,
   output logic       Rx_ValidFrame,
   output logic [7:0] Rx_Data,
   output logic       Rx_WrBuff,
   output logic       Rx_EoF,
   output logic       Rx_FrameError,
   output logic       Rx_Overflow
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   logic [7:0]       win_q, win_d;
   logic [7:0]       mask_q, mask_d;
   logic             flag_hit, abort_hit;
   logic             flag_q, abort_q;
   logic             bit_en, kept, byte_done;
   logic [7:0]       byte_val;
   logic [2:0]       bit_cnt;
   rx_state_t        state_q;
   logic             valid_q, abort_sig_q, eof_q, ferr_q, wr_q, ovf_q;
   logic [7:0]       data_q;
   logic [CNT_W-1:0] byte_cnt_q;

   // mask_q marks window positions that may still become data. Every bit
   // inside a detected flag/abort is unmarked, so pattern bits leaving the
   // window never reach the byte assembler.
   always_comb begin
      win_d     = 8'hFF;
      mask_d    = '0;
      flag_hit  = 1'b0;
      abort_hit = 1'b0;
      if (Rx_Enable) begin
         flag_hit  = (win_q == FLAG_PATTERN);
         abort_hit = (win_q == ABORT_PATTERN);
         win_d     = {win_q[6:0], Rx};
         mask_d    = (flag_hit || abort_hit) ? 8'h01 : {mask_q[6:0], 1'b1};
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         win_q   <= 8'hFF;
         mask_q  <= '0;
         flag_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         win_q   <= win_d;
         mask_q  <= mask_d;
         flag_q  <= flag_hit;
         abort_q <= abort_hit;
      end
   end

   assign bit_en = Rx_Enable && valid_q && mask_q[7] && !(flag_hit || abort_hit);

   hdlc_rx_destuff u_destuff (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .clear_i     (state_q == IDLE),
      .bit_i       (win_q[7]),
      .bit_en_i    (bit_en),
      .kept_o      (kept),
      .byte_done_o (byte_done),
      .byte_o      (byte_val),
      .bit_cnt_o   (bit_cnt)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         valid_q     <= 1'b0;
         abort_sig_q <= 1'b0;
         eof_q       <= 1'b0;
         ferr_q      <= 1'b0;
         wr_q        <= 1'b0;
         ovf_q       <= 1'b0;
         data_q      <= '0;
         byte_cnt_q  <= '0;
      end else begin
         abort_sig_q <= 1'b0;
         eof_q       <= 1'b0;
         ferr_q      <= 1'b0;
         wr_q        <= 1'b0;
         if (!Rx_Enable) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
         end else begin
            // Byte output runs ahead of the state update so a byte finishing
            // alongside the closing decision is still written before Rx_EoF.
            if (byte_done && valid_q) begin
               if (byte_cnt_q == MAX_CNT) begin
                  ovf_q <= 1'b1;
               end else begin
                  wr_q       <= 1'b1;
                  data_q     <= byte_val;
                  byte_cnt_q <= byte_cnt_q + CNT_W'(1);
               end
            end
            case (state_q)
               IDLE: begin
                  if (flag_q) begin
                     state_q    <= OPEN;
                     valid_q    <= 1'b1;
                     byte_cnt_q <= '0;
                     ovf_q      <= 1'b0;
                  end
               end
               OPEN: begin
                  if (abort_q) begin
                     state_q     <= IDLE;
                     valid_q     <= 1'b0;
                     abort_sig_q <= 1'b1;
                  end else if (kept) begin
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  if (abort_q) begin
                     state_q     <= IDLE;
                     valid_q     <= 1'b0;
                     abort_sig_q <= 1'b1;
                  end else if (flag_q) begin
                     state_q <= IDLE;
                     valid_q <= 1'b0;
                     eof_q   <= 1'b1;
                     ferr_q  <= (bit_cnt != 3'd0) || (byte_cnt_q == '0);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Rx_FlagDetect  = flag_q;
   assign Rx_AbortDetect = abort_q;
   assign Rx_AbortSignal = abort_sig_q;
   assign Rx_ValidFrame  = valid_q;
   assign Rx_Data        = data_q;
   assign Rx_WrBuff      = wr_q;
   assign Rx_EoF         = eof_q;
   assign Rx_FrameError  = ferr_q;
   assign Rx_Overflow    = ovf_q;

endmodule

// File: tb/tb_hdlc_rx_framer.sv
// Directed bench for hdlc_rx_framer. Line-level pulses (flag/abort detect) are
// predicted from the last eight bits driven; frame events are scheduled by
// cycle when the bench sends the bits that cause them; bytes go through an
// expected queue popped on each Rx_WrBuff.
module tb_hdlc_rx_framer;

   logic       Clk = 1'b0;
   logic       Rst, Rx, Rx_Enable;
   logic       Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame;
   logic [7:0] Rx_Data;
   logic       Rx_WrBuff, Rx_EoF, Rx_FrameError, Rx_Overflow;

   hdlc_rx_framer #(.MAX_BYTES(128), .CNT_W(8)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Rx             (Rx),
      .Rx_Enable      (Rx_Enable),
      .Rx_FlagDetect  (Rx_FlagDetect),
      .Rx_AbortDetect (Rx_AbortDetect),
      .Rx_AbortSignal (Rx_AbortSignal),
      .Rx_ValidFrame  (Rx_ValidFrame),
      .Rx_Data        (Rx_Data),
      .Rx_WrBuff      (Rx_WrBuff),
      .Rx_EoF         (Rx_EoF),
      .Rx_FrameError  (Rx_FrameError),
      .Rx_Overflow    (Rx_Overflow)
   );

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         ones_run = 0;
   logic [7:0] hist = 8'hFF;
   logic       pend_flag = 1'b0;
   logic       pend_abort = 1'b0;
   logic       exp_valid = 1'b0;
   logic [7:0] exp_q[$];
   int         eof_cyc_q[$];
   logic       eof_err_q[$];
   int         abs_cyc_q[$];
   int         vchg_cyc_q[$];
   logic       vchg_val_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Drives one bit for one clock, then checks every output in the next cycle.
   task automatic send_bit(input logic b);
      logic now_flag, now_abort, eof_now, abs_now;
      Rx        = b;
      hist      = {hist[6:0], b};
      now_flag  = (hist == 8'h7E);
      now_abort = (hist == 8'h7F);
      @(posedge Clk);
      #1;
      cyc++;
      while (vchg_cyc_q.size() > 0 && vchg_cyc_q[0] == cyc) begin
         exp_valid = vchg_val_q.pop_front();
         void'(vchg_cyc_q.pop_front());
      end
      check("flag_detect", Rx_FlagDetect, pend_flag);
      check("abort_detect", Rx_AbortDetect, pend_abort);
      check("valid_frame", Rx_ValidFrame, exp_valid);
      eof_now = (eof_cyc_q.size() > 0 && eof_cyc_q[0] == cyc);
      check("eof", Rx_EoF, eof_now);
      if (eof_now) begin
         void'(eof_cyc_q.pop_front());
         check("frame_error", Rx_FrameError, eof_err_q.pop_front());
      end
      abs_now = (abs_cyc_q.size() > 0 && abs_cyc_q[0] == cyc);
      check("abort_signal", Rx_AbortSignal, abs_now);
      if (abs_now) void'(abs_cyc_q.pop_front());
      if (Rx_WrBuff) begin
         if (exp_q.size() == 0) check("wrbuff_unexpected", Rx_WrBuff, 1'b0);
         else check("rx_data", Rx_Data, exp_q.pop_front());
      end
      pend_flag  = now_flag;
      pend_abort = now_abort;
   endtask

   task automatic idle(input int n);
      repeat (n) send_bit(1'b1);
   endtask

   // Data byte LSB first with transmitter-side zero insertion.
   task automatic send_byte(input logic [7:0] b, input bit expect_write);
      if (expect_write) exp_q.push_back(b);
      for (int i = 0; i < 8; i++) begin
         send_bit(b[i]);
         ones_run = b[i] ? ones_run + 1 : 0;
         if (ones_run == 5) begin
            send_bit(1'b0);
            ones_run = 0;
         end
      end
   endtask

   // kind 0: opening flag, 1: closing flag, 2: repeated flag in an open frame.
   task automatic send_flag(input int kind, input logic ferr);
      logic [7:0] pat;
      int t;
      pat = 8'h7E;
      for (int i = 7; i > 0; i--) send_bit(pat[i]);
      t = cyc;
      send_bit(pat[0]);
      if (kind == 0) begin
         vchg_cyc_q.push_back(t + 3);
         vchg_val_q.push_back(1'b1);
      end else if (kind == 1) begin
         eof_cyc_q.push_back(t + 3);
         eof_err_q.push_back(ferr);
         vchg_cyc_q.push_back(t + 3);
         vchg_val_q.push_back(1'b0);
      end
      ones_run = 0;
   endtask

   task automatic send_abort(input bit in_frame);
      int t;
      send_bit(1'b0);
      repeat (6) send_bit(1'b1);
      t = cyc;
      send_bit(1'b1);
      if (in_frame) begin
         abs_cyc_q.push_back(t + 3);
         vchg_cyc_q.push_back(t + 3);
         vchg_val_q.push_back(1'b0);
      end
      ones_run = 0;
   endtask

   task automatic do_reset(input int ncyc);
      Rst = 1'b1;
      Rx  = 1'b1;
      repeat (ncyc) begin
         @(posedge Clk);
         #1;
         cyc++;
      end
      check("rst_flag", Rx_FlagDetect, 1'b0);
      check("rst_abort", Rx_AbortDetect, 1'b0);
      check("rst_abort_sig", Rx_AbortSignal, 1'b0);
      check("rst_valid", Rx_ValidFrame, 1'b0);
      check("rst_data", Rx_Data, 8'h00);
      check("rst_wrbuff", Rx_WrBuff, 1'b0);
      check("rst_eof", Rx_EoF, 1'b0);
      check("rst_ferr", Rx_FrameError, 1'b0);
      check("rst_ovf", Rx_Overflow, 1'b0);
      hist       = 8'hFF;
      pend_flag  = 1'b0;
      pend_abort = 1'b0;
      exp_valid  = 1'b0;
      ones_run   = 0;
      exp_q.delete();
      eof_cyc_q.delete();
      eof_err_q.delete();
      abs_cyc_q.delete();
      vchg_cyc_q.delete();
      vchg_val_q.delete();
      Rst = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      Rst       = 1'b1;
      Rx        = 1'b1;
      Rx_Enable = 1'b1;
      do_reset(2);
      idle(4);

      // 1: flag, repeated flag, 0x5A, closing flag
      send_flag(0, 1'b0);
      send_flag(2, 1'b0);
      send_byte(8'h5A, 1'b1);
      send_flag(1, 1'b0);
      idle(10);

      // 2: 0xFF needs a stuffed zero
      send_flag(0, 1'b0);
      send_byte(8'hFF, 1'b1);
      send_flag(1, 1'b0);
      idle(10);

      // 3: abort inside a frame after one byte
      send_flag(0, 1'b0);
      send_byte(8'h12, 1'b1);
      send_abort(1'b1);
      idle(10);

      // 4: abort on an idle line
      idle(5);
      send_abort(1'b0);
      idle(5);

      // 5: 129 bytes, the last one overflows
      send_flag(0, 1'b0);
      for (int i = 0; i < 129; i++) begin
         send_byte(8'h00, i < 128);
         if (i == 127) check("ovf_before_limit", Rx_Overflow, 1'b0);
      end
      send_flag(1, 1'b0);
      idle(10);
      check("ovf_set", Rx_Overflow, 1'b1);

      // 6: next frame clears overflow; 12 data bits give a frame error
      send_flag(0, 1'b0);
      send_byte(8'hC3, 1'b1);
      check("ovf_cleared", Rx_Overflow, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_flag(1, 1'b1);
      idle(10);

      // reset in the middle of a frame
      send_flag(0, 1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      do_reset(1);
      idle(20);

      check("bytes_left", exp_q.size(), 0);
      check("eof_left", eof_cyc_q.size(), 0);
      check("abort_sig_left", abs_cyc_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hdlc_rx_framer.md
Name: hdlc_rx_framer

Overview:
Rx front-end of the HDLC receiver. It takes the serial line one bit per clock, detects flags and aborts, removes stuffed zeros and assembles LSB-first data bytes. It produces the Rx_FlagDetect, Rx_AbortDetect, Rx_AbortSignal, Rx_ValidFrame, Rx_Overflow and Rx_WrBuff signals consumed by the Rx buffer/controller. It sits directly between the Rx pin and the Rx buffer.

Parameters:
MAX_BYTES, 128, maximum data bytes per frame before overflow.
CNT_W, 8, byte-counter width; must satisfy 2**CNT_W > MAX_BYTES.

Ports:
Clk  input  1  system clock; all logic on rising edge.
Rst  input  1  synchronous reset, active-high.
Rx  input  1  serial line; one bit per Clk.
Rx_Enable  input  1  receiver enable.
Rx_FlagDetect  output  1  one-cycle pulse; flag 01111110 seen.
Rx_AbortDetect  output  1  one-cycle pulse; 0 followed by seven 1s seen.
Rx_AbortSignal  output  1  one-cycle pulse; abort occurred inside a frame.
Rx_ValidFrame  output  1  high while a frame is open.
Rx_Data  output  8  last assembled byte, LSB = first received bit.
Rx_WrBuff  output  1  one-cycle pulse; Rx_Data valid.
Rx_EoF  output  1  one-cycle pulse; frame closed by a flag.
Rx_FrameError  output  1  valid with Rx_EoF; non-octet-aligned frame.
Rx_Overflow  output  1  sticky; frame exceeded MAX_BYTES.

Behaviour:
- Reset: Rst=1 at a Clk edge forces all outputs to 0. The 8-bit window resets to 8'hFF (idle ones), so no false flag or abort is detected. Counters clear. Reset mid-frame discards the frame with no Rx_EoF.
- Rx_Enable=0: the window is held at 8'hFF, Rx_ValidFrame is forced to 0, and no pulses are generated.
- Window: Rx shifts in every cycle. The oldest bit is at window[7].
- Flag detect: window==8'h7E. If the closing 0 is on Rx in cycle t, Rx_FlagDetect is high in cycle t+2 for exactly one cycle.
- Abort detect: window==8'h7F, i.e. a 0 followed by seven 1s. Rx_AbortDetect is high at t+2, where t is the cycle of the 7th 1. Further consecutive 1s do not re-pulse.
- Data path: takes the bit leaving the window (Rx delayed 8 cycles), so flag and abort bits never enter a byte.
- Destuffing: a ones counter runs on the delayed stream. A 0 arriving with count==5 is discarded. Any 0 resets the count.
- Byte assembly: 8 kept bits form a byte, LSB first.
  - Rx_Data updates and Rx_WrBuff pulses for one cycle.
  - Byte count increments.
  - Bytes are assembled only while Rx_ValidFrame=1.
- Frame FSM states: IDLE, OPEN, DATA.
  - IDLE + flag -> OPEN. Rx_ValidFrame=1 from the cycle after Rx_FlagDetect. Clear byte count, bit count and Rx_Overflow.
  - OPEN + flag -> OPEN. Back-to-back flags; no Rx_EoF.
  - OPEN, first kept data bit -> DATA.
  - DATA + flag -> IDLE.
    - Rx_EoF pulses in the cycle after Rx_FlagDetect.
    - Rx_FrameError=1 if bit count mod 8 != 0 or byte count==0.
    - Rx_ValidFrame drops in the same cycle.
  - OPEN or DATA + abort -> IDLE. Rx_AbortSignal pulses at Rx_AbortDetect+1 and Rx_ValidFrame drops the same cycle. No Rx_EoF and no further Rx_WrBuff.
  - Abort in IDLE: Rx_AbortDetect pulses; Rx_AbortSignal stays 0.
- Overflow: when a byte completes with byte count==MAX_BYTES, Rx_Overflow=1 and that byte is not written (no Rx_WrBuff). Rx_Overflow stays high until the next opening flag or reset. The frame still closes normally with Rx_EoF.
- Simultaneous events: flag and abort patterns are mutually exclusive in the window. A byte completing in the same cycle as the closing-flag decision is written before Rx_EoF.

Decomposition:
- hdlc_pkg:
  - FLAG_PATTERN = 8'h7E
  - ABORT_PATTERN = 8'h7F
  - STUFF_ONES = 5
  - rx_state_t enum {IDLE, OPEN, DATA}
- Sub-module hdlc_rx_destuff: ones counter, zero removal, byte shift register and bit count. Outputs kept-bit strobe, byte-complete strobe and byte.
- Top level: window, detectors, FSM, byte counter and overflow.

Test Plan:
1. Flag then 0x5A (no stuffing) then flag -> Rx_FlagDetect at closing 0 +2 for each flag; one Rx_WrBuff with Rx_Data=8'h5A; Rx_EoF=1, Rx_FrameError=0; Rx_ValidFrame low after.
2. Flag, data 0xFF (sent as 11111 0 111), flag -> stuffed 0 removed; Rx_Data=8'hFF; exactly one Rx_WrBuff.
3. Flag, 0x12, then 0 + 7 ones -> Rx_AbortDetect at 7th 1 +2; Rx_AbortSignal one cycle later; Rx_ValidFrame=0; no Rx_EoF.
4. Idle ones then 0 + 7 ones outside a frame -> Rx_AbortDetect=1, Rx_AbortSignal=0.
5. Flag, 129 bytes of 0x00, flag -> 128 Rx_WrBuff pulses; Rx_Overflow=1 at the 129th byte; Rx_EoF still pulses; next opening flag clears Rx_Overflow.
6. Flag, 12 data bits, flag -> Rx_EoF=1 with Rx_FrameError=1. Separately, Rst=1 mid-frame -> all outputs 0 next cycle.
